// File: rtl/dec_scan.sv
// Registered one-hot decoder/sequencer: holds a selected index, decodes it to
// a single asserted line, and can walk that line up or down with terminal-count flagging.
module dec_scan #(
  parameter int N    = 4,
  parameter bit WRAP = 1'b1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [N-1:0]      w,
  input  logic              En,
  input  logic              Clear,
  input  logic              Load,
  input  logic              Scan,
  input  logic              Dir,
  output logic [0:(2**N)-1] y,
  output logic [N-1:0]      Idx,
  output logic              Active,
  output logic              Wrap
);

  localparam int M = 2**N;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [N-1:0] idx_q, idx_d;
  logic         wrap_q, wrap_d;
  logic         at_bound;

  // Terminal position depends on the walk direction.
  assign at_bound = Dir ? (idx_q == '0) : (idx_q == '1);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    if (Clear) begin
      state_d = ST_IDLE;
    end else if (Load) begin
      idx_d   = w;
      state_d = ST_RUN;
    end else if (Scan && (state_q == ST_RUN)) begin
      if (at_bound) begin
        wrap_d = 1'b1;
        if (WRAP) idx_d = Dir ? '1 : '0;
        else      state_d = ST_IDLE;
      end else begin
        idx_d = Dir ? (idx_q - 1'b1) : (idx_q + 1'b1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
    end
  end

  // En gates only the select lines, combinationally, never the held state.
  always_comb begin
    y = '0;
    for (int i = 0; i < M; i++) begin
      y[i] = En && (state_q == ST_RUN) && (idx_q == N'(i));
    end
  end

  assign Idx    = idx_q;
  assign Active = (state_q == ST_RUN);
  assign Wrap   = wrap_q;

endmodule

// File: tb/tb_dec_scan.sv
// Bench for dec_scan: four instances (N=4 wrap, N=4 stop, N=2, N=6) share one
// stimulus stream; an arithmetic reference model feeds a scoreboard queue.
module tb_dec_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, clr, ld, sc, dir;
  logic [5:0] w_bus;

  logic [0:15] y_a, y_b;
  logic [0:3]  y_c;
  logic [0:63] y_d;
  logic [3:0]  idx_a, idx_b;
  logic [1:0]  idx_c;
  logic [5:0]  idx_d;
  logic        act_a, act_b, act_c, act_d;
  logic        wr_a, wr_b, wr_c, wr_d;

  always #5 clk = ~clk;

  dec_scan #(.N(4), .WRAP(1'b1)) u_a (
    .Clock(clk), .Resetn(rst_n), .w(w_bus[3:0]), .En(en), .Clear(clr), .Load(ld),
    .Scan(sc), .Dir(dir), .y(y_a), .Idx(idx_a), .Active(act_a), .Wrap(wr_a));
  dec_scan #(.N(4), .WRAP(1'b0)) u_b (
    .Clock(clk), .Resetn(rst_n), .w(w_bus[3:0]), .En(en), .Clear(clr), .Load(ld),
    .Scan(sc), .Dir(dir), .y(y_b), .Idx(idx_b), .Active(act_b), .Wrap(wr_b));
  dec_scan #(.N(2), .WRAP(1'b1)) u_c (
    .Clock(clk), .Resetn(rst_n), .w(w_bus[1:0]), .En(en), .Clear(clr), .Load(ld),
    .Scan(sc), .Dir(dir), .y(y_c), .Idx(idx_c), .Active(act_c), .Wrap(wr_c));
  dec_scan #(.N(6), .WRAP(1'b1)) u_d (
    .Clock(clk), .Resetn(rst_n), .w(w_bus), .En(en), .Clear(clr), .Load(ld),
    .Scan(sc), .Dir(dir), .y(y_d), .Idx(idx_d), .Active(act_d), .Wrap(wr_d));

  typedef struct packed {
    logic [3:0][5:0] idx;
    logic [3:0]      act;
    logic [3:0]      wr;
    logic            en;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: plain integer index per instance.
  int m_idx [4];
  bit m_act [4];
  bit m_wr  [4];

  function automatic int msize(int k);
    case (k)
      2:       return 4;
      3:       return 64;
      default: return 16;
    endcase
  endfunction

  function automatic bit mwrap(int k);
    return (k != 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_idx[k] = 0; m_act[k] = 1'b0; m_wr[k] = 1'b0;
    end
  endtask

  task automatic model_step(bit c, bit l, bit s, bit d, logic [5:0] wv);
    for (int k = 0; k < 4; k++) begin
      int nxt;
      m_wr[k] = 1'b0;
      if (c) begin
        m_act[k] = 1'b0;
      end else if (l) begin
        m_idx[k] = int'(wv) % msize(k);
        m_act[k] = 1'b1;
      end else if (s && m_act[k]) begin
        nxt = d ? m_idx[k] - 1 : m_idx[k] + 1;
        if (nxt < 0 || nxt >= msize(k)) begin
          m_wr[k] = 1'b1;
          if (mwrap(k)) m_idx[k] = (nxt + msize(k)) % msize(k);
          else          m_act[k] = 1'b0;
        end else begin
          m_idx[k] = nxt;
        end
      end
    end
  endtask

  function automatic exp_t snap(bit e);
    exp_t r;
    for (int k = 0; k < 4; k++) begin
      r.idx[k] = 6'(m_idx[k]);
      r.act[k] = m_act[k];
      r.wr[k]  = m_wr[k];
    end
    r.en = e;
    return r;
  endfunction

  function automatic logic [63:0] exp_mask(exp_t e, int k);
    return (e.en && e.act[k]) ? (64'd1 << e.idx[k]) : 64'd0;
  endfunction

  task automatic check(string name, int k, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s[inst %0d] at %0t: got %0h, expected %0h", name, k, $time, got, want);
  endtask

  task automatic check_all(string tag, exp_t e);
    logic [63:0] m;
    m = '0; for (int i = 0; i < 16; i++) m[i] = y_a[i];
    check({tag, "_y"}, 0, m, exp_mask(e, 0));
    m = '0; for (int i = 0; i < 16; i++) m[i] = y_b[i];
    check({tag, "_y"}, 1, m, exp_mask(e, 1));
    m = '0; for (int i = 0; i < 4; i++) m[i] = y_c[i];
    check({tag, "_y"}, 2, m, exp_mask(e, 2));
    m = '0; for (int i = 0; i < 64; i++) m[i] = y_d[i];
    check({tag, "_y"}, 3, m, exp_mask(e, 3));
    check({tag, "_idx"}, 0, 64'(idx_a), 64'(e.idx[0]));
    check({tag, "_idx"}, 1, 64'(idx_b), 64'(e.idx[1]));
    check({tag, "_idx"}, 2, 64'(idx_c), 64'(e.idx[2]));
    check({tag, "_idx"}, 3, 64'(idx_d), 64'(e.idx[3]));
    check({tag, "_active"}, 0, 64'(act_a), 64'(e.act[0]));
    check({tag, "_active"}, 1, 64'(act_b), 64'(e.act[1]));
    check({tag, "_active"}, 2, 64'(act_c), 64'(e.act[2]));
    check({tag, "_active"}, 3, 64'(act_d), 64'(e.act[3]));
    check({tag, "_wrap"}, 0, 64'(wr_a), 64'(e.wr[0]));
    check({tag, "_wrap"}, 1, 64'(wr_b), 64'(e.wr[1]));
    check({tag, "_wrap"}, 2, 64'(wr_c), 64'(e.wr[2]));
    check({tag, "_wrap"}, 3, 64'(wr_d), 64'(e.wr[3]));
  endtask

  // Monitor: registered outputs are compared just after each edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) check_all("sb", sb.pop_front());
  end

  task automatic cycle(bit e, bit c, bit l, bit s, bit d, logic [5:0] wv);
    @(negedge clk);
    en = e; clr = c; ld = l; sc = s; dir = d; w_bus = wv;
    model_step(c, l, s, d, wv);
    sb.push_back(snap(e));
  endtask

  // Flip En between edges and look at y right away.
  task automatic en_probe(bit e);
    @(posedge clk);
    #3;
    en = e;
    #1;
    check_all("en_probe", snap(e));
  endtask

  task automatic reset_now();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset", snap(en));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    en = 1'b1; clr = 1'b0; ld = 1'b0; sc = 1'b0; dir = 1'b0; w_bus = '0;
    model_reset();
    #1;
    check_all("reset_init", snap(1'b1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Load 5, walk a bit, then reset mid-scan and load 5 again.
    cycle(1, 0, 1, 0, 0, 6'd5);
    cycle(1, 0, 0, 1, 0, 6'd0);
    cycle(1, 0, 0, 1, 0, 6'd0);
    reset_now();
    cycle(1, 0, 0, 1, 0, 6'd0);
    cycle(1, 0, 1, 0, 0, 6'd5);

    // Decode sweep with En toggling.
    for (int v = 0; v < 16; v++) begin
      cycle(1'(v & 1), 0, 1, 0, 0, 6'(v));
      cycle(~1'(v & 1), 0, 0, 0, 0, 6'd0);
    end
    en_probe(1'b0);
    en_probe(1'b1);

    // Up scan across the top, then down scan into the bottom.
    cycle(1, 0, 1, 0, 0, 6'd14);
    repeat (3) cycle(1, 0, 0, 1, 0, 6'd0);
    cycle(1, 0, 1, 0, 1, 6'd1);
    repeat (3) cycle(1, 0, 0, 1, 1, 6'd0);

    // Priority: Load beats Scan, Clear beats Load, Scan while idle.
    cycle(1, 0, 1, 1, 0, 6'd3);
    cycle(1, 1, 1, 1, 0, 6'd9);
    cycle(1, 0, 0, 1, 0, 6'd0);
    cycle(1, 0, 0, 1, 1, 6'd0);

    // Full up scan from 0 through two wraps of the widest instance.
    cycle(1, 0, 1, 0, 0, 6'd0);
    repeat (130) cycle(1, 0, 0, 1, 0, 6'd0);
    repeat (70) cycle(1, 0, 0, 1, 1, 6'd0);

    // Randomised commands.
    for (int t = 0; t < 400; t++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 6'($urandom_range(0, 63)));
      if (t == 200) reset_now();
    end

    cycle(1, 0, 0, 0, 0, 6'd0);
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    check("drain", 0, 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
